cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller_pkg.sv | 17 +
 rtl/cache_controller.sv | 151 +++++++++++++++
 tb/tb_cache_controller.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_pkg.sv
// Shared types and sizing for the blocking read-allocate / write-through cache controller.
package cache_controller_pkg;

  localparam int BASE_ADDR_DEF = 1024;
  localparam int ADR_W_DEF     = 19;
  localparam int LINE_W        = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_FILL  = 3'd3,
    ST_WR    = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/cache_controller.sv
// Cache front-end: zero-latency hits, two-beat SRAM line refill on a miss,
// and write-through stores that invalidate the matching cache line.
//
//   state  | meaning
//   IDLE   | serve hits, dispatch misses and stores
//   RD_LO  | fetch line word at offset 0
//   RD_HI  | fetch line word at offset 4
//   FILL   | write the assembled line into the cache
//   WR     | write store word through to SRAM
//   DONE   | release the pipeline for one cycle
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int BASE_ADDR = BASE_ADDR_DEF,
  parameter int ADR_W     = ADR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [ADR_W-1:0]  cch_adr,
  output logic              cch_read_en,
  output logic              cch_write_en,
  output logic              cch_update,
  output logic [LINE_W-1:0] cch_write_data,
  input  logic              cch_miss,
  input  logic [31:0]       cch_read_data,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADR_W-1:0]  sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_ack
);

  state_e r_state, w_next;
  logic [31:0] r_lo_buf, r_hi_buf;
  logic        r_was_rd;

  logic [31:0]      w_offset_full;
  logic [ADR_W-1:0] w_offset;
  logic             w_unused_offset_hi;

  assign w_offset_full      = address - 32'(BASE_ADDR);
  assign w_offset           = w_offset_full[ADR_W-1:0];
  assign w_unused_offset_hi = ^w_offset_full[31:ADR_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_lo_buf <= '0;
      r_hi_buf <= '0;
      r_was_rd <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_RD_LO && sram_ack) r_lo_buf <= sram_rdata;
      if (r_state == ST_RD_HI && sram_ack) r_hi_buf <= sram_rdata;
      if (r_state == ST_IDLE) begin
        if (mem_w_en)                  r_was_rd <= 1'b0;
        else if (mem_r_en && cch_miss) r_was_rd <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    ready          = 1'b0;
    rdata          = '0;
    cch_adr        = w_offset;
    cch_read_en    = mem_r_en;
    cch_write_en   = mem_w_en;
    cch_update     = 1'b0;
    cch_write_data = '0;
    sram_req       = 1'b0;
    sram_we        = 1'b0;
    sram_addr      = '0;
    sram_wdata     = '0;

    unique case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (mem_w_en) begin
          ready  = 1'b0;
          w_next = ST_WR;
        end else if (mem_r_en) begin
          if (cch_miss) begin
            ready  = 1'b0;
            w_next = ST_RD_LO;
          end else begin
            rdata = cch_read_data;
          end
        end
      end
      ST_RD_LO: begin
        sram_req  = 1'b1;
        sram_addr = {w_offset[ADR_W-1:3], 3'b000};
        if (sram_ack) w_next = ST_RD_HI;
      end
      ST_RD_HI: begin
        sram_req  = 1'b1;
        sram_addr = {w_offset[ADR_W-1:3], 3'b100};
        if (sram_ack) w_next = ST_FILL;
      end
      ST_FILL: begin
        cch_update     = 1'b1;
        cch_write_data = {r_lo_buf, r_hi_buf};
        w_next         = ST_DONE;
      end
      ST_WR: begin
        sram_req   = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = {w_offset[ADR_W-1:2], 2'b00};
        sram_wdata = wdata;
        // Invalidate on ack so a stale hit line never outlives the store.
        if (sram_ack) begin
          cch_update = 1'b1;
          w_next     = ST_DONE;
        end
      end
      ST_DONE: begin
        ready        = 1'b1;
        cch_read_en  = 1'b0;
        cch_write_en = 1'b0;
        if (r_was_rd) rdata = w_offset[2] ? r_hi_buf : r_lo_buf;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase

    // Reset is synchronous, so mask outputs while it is held to abandon any transfer cleanly.
    if (rst) begin
      w_next         = ST_IDLE;
      ready          = 1'b1;
      rdata          = '0;
      cch_adr        = '0;
      cch_read_en    = 1'b0;
      cch_write_en   = 1'b0;
      cch_update     = 1'b0;
      cch_write_data = '0;
      sram_req       = 1'b0;
      sram_we        = 1'b0;
      sram_addr      = '0;
      sram_wdata     = '0;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: hit, miss refill, store, priority, reset abort, spurious ack.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic [18:0] cch_adr;
  logic        cch_read_en, cch_write_en, cch_update;
  logic [63:0] cch_write_data;
  logic        cch_miss;
  logic [31:0] cch_read_data;
  logic        sram_req, sram_we;
  logic [18:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        sram_ack;

  int n_checks = 0;
  int n_pass   = 0;
  int ready_low;

  always #5 clk = ~clk;

  cache_controller #(.BASE_ADDR(1024), .ADR_W(19)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .cch_adr(cch_adr), .cch_read_en(cch_read_en), .cch_write_en(cch_write_en),
    .cch_update(cch_update), .cch_write_data(cch_write_data),
    .cch_miss(cch_miss), .cch_read_data(cch_read_data),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ack(sram_ack)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    #1;
    if (ready !== 1'b1) ready_low++;
    @(posedge clk);
    #1;
  endtask

  // Holds off the ack for lat cycles, then acks with data; checks the SRAM request each cycle.
  task automatic serve(input string tag, input int lat, input logic [31:0] data,
                       input logic [18:0] exp_addr, input logic exp_we, input logic [31:0] exp_wd);
    for (int i = 0; i < lat; i++) begin
      #1;
      check({tag, "_req"}, 64'(sram_req), 64'd1);
      check({tag, "_addr"}, 64'(sram_addr), 64'(exp_addr));
      check({tag, "_upd_wait"}, 64'(cch_update), 64'd0);
      tick();
    end
    sram_ack   = 1'b1;
    sram_rdata = data;
    #1;
    check({tag, "_req_ack"}, 64'(sram_req), 64'd1);
    check({tag, "_addr_ack"}, 64'(sram_addr), 64'(exp_addr));
    check({tag, "_we"}, 64'(sram_we), 64'(exp_we));
    check({tag, "_wdata"}, 64'(sram_wdata), 64'(exp_wd));
    tick();
    sram_ack   = 1'b0;
    sram_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_r_en = 0; mem_w_en = 0; address = 32'h400; wdata = 0;
    cch_miss = 0; cch_read_data = 0; sram_rdata = 0; sram_ack = 0;
    tick(); tick();
    // reset outputs
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_sram_req", 64'(sram_req), 64'd0);
    check("rst_update", 64'(cch_update), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_lo_buf", 64'(dut.r_lo_buf), 64'd0);
    rst = 1'b0;
    tick();

    // read hit
    address = 32'h408; cch_miss = 0; cch_read_data = 32'hDEADBEEF; mem_r_en = 1;
    #1;
    check("hit_ready", 64'(ready), 64'd1);
    check("hit_rdata", 64'(rdata), 64'hDEADBEEF);
    check("hit_rd_en", 64'(cch_read_en), 64'd1);
    check("hit_cch_adr", 64'(cch_adr), 64'h008);
    tick();
    check("hit_sram_req", 64'(sram_req), 64'd0);
    check("hit_ready2", 64'(ready), 64'd1);
    mem_r_en = 0;
    tick();

    // read miss at 0x40C with 3-cycle ack latency per word
    address = 32'h40C; cch_miss = 1; mem_r_en = 1; ready_low = 0;
    #1;
    check("miss_ready", 64'(ready), 64'd0);
    tick();
    serve("miss_lo", 3, 32'h11111111, 19'h008, 1'b0, 32'h0);
    serve("miss_hi", 3, 32'h22222222, 19'h00C, 1'b0, 32'h0);
    check("fill_update", 64'(cch_update), 64'd1);
    check("fill_data", cch_write_data, 64'h1111111122222222);
    tick();
    check("done_ready", 64'(ready), 64'd1);
    check("done_rdata", 64'(rdata), 64'h22222222);
    check("done_update", 64'(cch_update), 64'd0);
    check("done_rd_en", 64'(cch_read_en), 64'd0);
    check("miss_ready_low", 64'(ready_low), 64'd10);
    tick();
    mem_r_en = 0; cch_miss = 0;
    #1;
    check("post_miss_ready", 64'(ready), 64'd1);
    tick();

    // store to 0x410
    address = 32'h410; wdata = 32'hCAFEF00D; mem_w_en = 1;
    #1;
    check("st_ready", 64'(ready), 64'd0);
    check("st_wr_en", 64'(cch_write_en), 64'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      check("st_wait_upd", 64'(cch_update), 64'd0);
      tick();
    end
    sram_ack = 1'b1;
    #1;
    check("st_we", 64'(sram_we), 64'd1);
    check("st_addr", 64'(sram_addr), 64'h010);
    check("st_wdata", 64'(sram_wdata), 64'hCAFEF00D);
    check("st_update_ack", 64'(cch_update), 64'd1);
    tick();
    sram_ack = 1'b0;
    #1;
    check("st_done_ready", 64'(ready), 64'd1);
    check("st_done_update", 64'(cch_update), 64'd0);
    check("st_done_rdata", 64'(rdata), 64'd0);
    tick();
    mem_w_en = 0;
    tick();

    // simultaneous read+write: write wins, byte bits cleared
    address = 32'h41A; wdata = 32'h0BADF00D; mem_r_en = 1; mem_w_en = 1; cch_miss = 1;
    #1;
    check("both_ready", 64'(ready), 64'd0);
    tick();
    serve("both_wr", 1, 32'h0, 19'h018, 1'b1, 32'h0BADF00D);
    check("both_done_rdata", 64'(rdata), 64'd0);
    check("both_done_ready", 64'(ready), 64'd1);
    tick();
    mem_r_en = 0; mem_w_en = 0; cch_miss = 0;
    tick();

    // reset during RD_HI, then refetch both words
    address = 32'h404; cch_miss = 1; mem_r_en = 1;
    tick();
    serve("abort_lo", 0, 32'hAAAAAAAA, 19'h000, 1'b0, 32'h0);
    #1;
    check("abort_rdhi_addr", 64'(sram_addr), 64'h004);
    rst = 1'b1;
    #1;
    check("abort_rst_req", 64'(sram_req), 64'd0);
    check("abort_rst_update", 64'(cch_update), 64'd0);
    check("abort_rst_ready", 64'(ready), 64'd1);
    tick();
    rst = 1'b0;
    #1;
    check("abort_idle_req", 64'(sram_req), 64'd0);
    check("abort_idle_update", 64'(cch_update), 64'd0);
    check("abort_idle_ready", 64'(ready), 64'd0);
    tick();
    serve("refetch_lo", 1, 32'h33333333, 19'h000, 1'b0, 32'h0);
    serve("refetch_hi", 2, 32'h44444444, 19'h004, 1'b0, 32'h0);
    check("refetch_fill", cch_write_data, 64'h3333333344444444);
    tick();
    check("refetch_rdata", 64'(rdata), 64'h44444444);
    tick();
    mem_r_en = 0; cch_miss = 0;
    tick();

    // spurious ack in IDLE
    sram_ack = 1'b1; sram_rdata = 32'h99999999;
    #1;
    check("spur_req", 64'(sram_req), 64'd0);
    check("spur_ready", 64'(ready), 64'd1);
    tick();
    sram_ack = 1'b0; sram_rdata = 0;
    #1;
    check("spur_lo_buf", 64'(dut.r_lo_buf), 64'h33333333);
    check("spur_hi_buf", 64'(dut.r_hi_buf), 64'h44444444);
    check("spur_update", 64'(cch_update), 64'd0);
    check("spur_still_idle", 64'(ready), 64'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
